square_root_iter: RTL and testbench

- Parametrised multi-cycle integer square root unit. Successor to the fixed 32-bit per-bit cell chain.
- Takes one P_WIDTH-bit unsigned radicand per transaction and returns floor(sqrt(x)) plus the remainder.
- Resolves P_BITS_PER_CYCLE root bits per clock, using the digit-by-digit (restoring) method.
- Uses the same REQ/BUSY/VALID handshake as the existing square-root datapath, so it drops into that pipeline, and carries a sideband tag through.

---
 rtl/square_root_iter.sv | 130 +++++++++++++
 tb/tb_square_root_iter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/square_root_iter.sv
// Multi-cycle integer square root using the restoring digit-by-digit method.
// Resolves P_BITS_PER_CYCLE root bits per clock and carries a tag through with REQ/BUSY/VALID handshakes.
module square_root_iter #(
    parameter int P_WIDTH          = 32,
    parameter int P_BITS_PER_CYCLE = 1,
    parameter int P_TAG_W          = 4
) (
    input  logic                   iCLOCK,
    input  logic                   inRESET,
    input  logic                   iDATA_REQ,
    output logic                   oDATA_BUSY,
    input  logic [P_WIDTH-1:0]     iDATA_X,
    input  logic [P_TAG_W-1:0]     iDATA_TAG,
    output logic                   oDATA_VALID,
    input  logic                   iDATA_BUSY,
    output logic [P_WIDTH/2-1:0]   oDATA_ROOT,
    output logic [P_WIDTH/2:0]     oDATA_REM,
    output logic [P_TAG_W-1:0]     oDATA_TAG
);

    localparam int HW = P_WIDTH / 2;
    localparam int RW = HW + 2;
    localparam int L  = HW / ((P_BITS_PER_CYCLE > 0) ? P_BITS_PER_CYCLE : 1);
    localparam int CW = $clog2(L + 1);

    generate
        if ((P_WIDTH % 2) != 0 || P_WIDTH < 4 ||
            !(P_BITS_PER_CYCLE == 1 || P_BITS_PER_CYCLE == 2 || P_BITS_PER_CYCLE == 4) ||
            (HW % ((P_BITS_PER_CYCLE > 0) ? P_BITS_PER_CYCLE : 1)) != 0 ||
            P_TAG_W < 1) begin : g_param_check
            $error("square_root_iter: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t               state, state_nxt;
    logic [P_WIDTH-1:0]   x_sh, x_nxt;
    logic [RW-1:0]        rem_r, rem_nxt;
    logic [HW-1:0]        root_r, root_nxt;
    logic [RW-1:0]        r_sh, trial;
    logic [CW-1:0]        cnt;
    logic [P_TAG_W-1:0]   tag_r;

    assign oDATA_BUSY  = (state != IDLE);
    assign oDATA_VALID = (state == DONE);

    // One cycle's worth of iterations; the unsigned compare stands in for the sign of t.
    always_comb begin
        x_nxt    = x_sh;
        rem_nxt  = rem_r;
        root_nxt = root_r;
        r_sh     = '0;
        trial    = '0;
        for (int i = 0; i < P_BITS_PER_CYCLE; i++) begin
            r_sh  = {rem_nxt[RW-3:0], x_nxt[P_WIDTH-1 -: 2]};
            trial = {root_nxt, 2'b01};
            if (r_sh >= trial) begin
                rem_nxt  = r_sh - trial;
                root_nxt = {root_nxt[HW-2:0], 1'b1};
            end else begin
                rem_nxt  = r_sh;
                root_nxt = {root_nxt[HW-2:0], 1'b0};
            end
            x_nxt = {x_nxt[P_WIDTH-3:0], 2'b00};
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (iDATA_REQ) state_nxt = CALC;
            CALC:    if (cnt == '0) state_nxt = DONE;
            DONE:    if (!iDATA_BUSY) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The counter hits zero one cycle before DONE; that idle CALC cycle publishes the result.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            x_sh       <= '0;
            rem_r      <= '0;
            root_r     <= '0;
            cnt        <= '0;
            tag_r      <= '0;
            oDATA_ROOT <= '0;
            oDATA_REM  <= '0;
            oDATA_TAG  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (iDATA_REQ) begin
                        x_sh   <= iDATA_X;
                        tag_r  <= iDATA_TAG;
                        rem_r  <= '0;
                        root_r <= '0;
                        cnt    <= CW'(L);
                    end
                end
                CALC: begin
                    if (cnt != '0) begin
                        x_sh   <= x_nxt;
                        rem_r  <= rem_nxt;
                        root_r <= root_nxt;
                        cnt    <= cnt - 1'b1;
                    end else begin
                        oDATA_ROOT <= root_r;
                        oDATA_REM  <= rem_r[HW:0];
                        oDATA_TAG  <= tag_r;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_square_root_iter.sv
// Directed bench for square_root_iter: a 32-bit/1-bit-per-cycle unit and a 16-bit/2-bits-per-cycle unit.
module tb_square_root_iter;

    logic        clk;
    logic        rst_n;

    logic        req_a, busy_a, valid_a, dbusy_a;
    logic [31:0] x_a;
    logic [3:0]  tag_a, otag_a;
    logic [15:0] root_a;
    logic [16:0] rem_a;

    logic        req_b, busy_b, valid_b, dbusy_b;
    logic [15:0] x_b;
    logic [3:0]  tag_b, otag_b;
    logic [7:0]  root_b;
    logic [8:0]  rem_b;

    int checks = 0;
    int errors = 0;

    square_root_iter #(.P_WIDTH(32), .P_BITS_PER_CYCLE(1), .P_TAG_W(4)) dut_a (
        .iCLOCK     (clk),
        .inRESET    (rst_n),
        .iDATA_REQ  (req_a),
        .oDATA_BUSY (busy_a),
        .iDATA_X    (x_a),
        .iDATA_TAG  (tag_a),
        .oDATA_VALID(valid_a),
        .iDATA_BUSY (dbusy_a),
        .oDATA_ROOT (root_a),
        .oDATA_REM  (rem_a),
        .oDATA_TAG  (otag_a)
    );

    square_root_iter #(.P_WIDTH(16), .P_BITS_PER_CYCLE(2), .P_TAG_W(4)) dut_b (
        .iCLOCK     (clk),
        .inRESET    (rst_n),
        .iDATA_REQ  (req_b),
        .oDATA_BUSY (busy_b),
        .iDATA_X    (x_b),
        .iDATA_TAG  (tag_b),
        .oDATA_VALID(valid_b),
        .iDATA_BUSY (dbusy_b),
        .oDATA_ROOT (root_b),
        .oDATA_REM  (rem_b),
        .oDATA_TAG  (otag_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request on the 32-bit unit and wait (bounded) until its result is valid.
    task automatic apply_stimulus(input logic [31:0] x, input logic [3:0] tag, output int lat);
        int guard = 0;
        while (busy_a && guard < 200) begin
            tick();
            guard++;
        end
        req_a = 1'b1;
        x_a   = x;
        tag_a = tag;
        tick();
        req_a = 1'b0;
        lat   = 0;
        while (!valid_a && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic check_txn(input string name, input logic [31:0] er, input logic [31:0] erem,
                             input logic [31:0] etag, input int lat);
        check_output({name, "_lat"}, lat, 17);
        check_output({name, "_valid"}, {31'd0, valid_a}, 1);
        check_output({name, "_root"}, {16'd0, root_a}, er);
        check_output({name, "_rem"}, {15'd0, rem_a}, erem);
        check_output({name, "_tag"}, {28'd0, otag_a}, etag);
        tick();
    endtask

    // Small unit: checks latency and the defining properties of floor sqrt and remainder.
    task automatic sweep_one(input int x);
        int lat = 0;
        int r, m;
        int guard = 0;
        while (busy_b && guard < 50) begin
            tick();
            guard++;
        end
        req_b = 1'b1;
        x_b   = 16'(x);
        tag_b = 4'(x);
        tick();
        req_b = 1'b0;
        while (!valid_b && lat < 50) begin
            tick();
            lat++;
        end
        r = int'(root_b);
        m = int'(rem_b);
        check_output("sw_lat", lat, 5);
        check_output("sw_lo", {31'd0, (r * r <= x)}, 1);
        check_output("sw_hi", {31'd0, (x < (r + 1) * (r + 1))}, 1);
        check_output("sw_rem", m, x - r * r);
        check_output("sw_tag", {28'd0, otag_b}, {28'd0, 4'(x)});
        tick();
    endtask

    initial begin
        int lat;
        int busy_cnt;
        int vpulse;
        req_a = 0; x_a = 0; tag_a = 0; dbusy_a = 0;
        req_b = 0; x_b = 0; tag_b = 0; dbusy_b = 0;
        rst_n = 1'b0;
        #3;
        check_output("rst_valid", {31'd0, valid_a}, 0);
        check_output("rst_busy", {31'd0, busy_a}, 0);
        check_output("rst_root", {16'd0, root_a}, 0);
        check_output("rst_rem", {15'd0, rem_a}, 0);
        check_output("rst_tag", {28'd0, otag_a}, 0);
        #19;
        rst_n = 1'b1;
        tick();

        $display("[TB] basic 1000000 with busy-cycle count");
        req_a = 1'b1; x_a = 32'd1000000; tag_a = 4'd3;
        tick();
        req_a = 1'b0;
        busy_cnt = busy_a ? 1 : 0;
        lat = 0;
        while (!valid_a && lat < 200) begin
            tick();
            lat++;
            if (busy_a) busy_cnt++;
        end
        check_output("t1_lat", lat, 17);
        check_output("t1_root", {16'd0, root_a}, 1000);
        check_output("t1_rem", {15'd0, rem_a}, 0);
        check_output("t1_tag", {28'd0, otag_a}, 3);
        tick();
        check_output("t1_busy_cycles", busy_cnt, 18);
        check_output("t1_busy_after", {31'd0, busy_a}, 0);
        check_output("t1_valid_after", {31'd0, valid_a}, 0);

        $display("[TB] small radicands and full scale");
        apply_stimulus(32'd99, 4'd1, lat);         check_txn("x99", 9, 18, 1, lat);
        apply_stimulus(32'd0, 4'd2, lat);          check_txn("x0", 0, 0, 2, lat);
        apply_stimulus(32'd1, 4'd4, lat);          check_txn("x1", 1, 0, 4, lat);
        apply_stimulus(32'd2, 4'd8, lat);          check_txn("x2", 1, 1, 8, lat);
        apply_stimulus(32'hFFFFFFFF, 4'd15, lat);  check_txn("xmax", 32'hFFFF, 32'h1FFFE, 15, lat);
        apply_stimulus(32'd4294836225, 4'd9, lat); check_txn("x65535sq", 32'hFFFF, 0, 9, lat);

        $display("[TB] downstream stall with pending request");
        dbusy_a = 1'b1;
        req_a = 1'b1; x_a = 32'd99; tag_a = 4'd5;
        tick();
        x_a = 32'd2; tag_a = 4'd6;
        lat = 0;
        while (!valid_a && lat < 200) begin
            tick();
            lat++;
        end
        check_output("t4_lat", lat, 17);
        for (int i = 0; i < 5; i++) begin
            check_output("t4_hold_valid", {31'd0, valid_a}, 1);
            check_output("t4_hold_root", {16'd0, root_a}, 9);
            check_output("t4_hold_rem", {15'd0, rem_a}, 18);
            check_output("t4_hold_tag", {28'd0, otag_a}, 5);
            check_output("t4_hold_busy", {31'd0, busy_a}, 1);
            if (i == 4) dbusy_a = 1'b0;
            tick();
        end
        check_output("t4_release_valid", {31'd0, valid_a}, 0);
        check_output("t4_release_busy", {31'd0, busy_a}, 0);
        tick();
        check_output("t4_reaccept_busy", {31'd0, busy_a}, 1);
        req_a = 1'b0;
        lat = 0;
        while (!valid_a && lat < 200) begin
            tick();
            lat++;
        end
        check_txn("t4_second", 1, 1, 6, lat);

        $display("[TB] reset during calculation");
        req_a = 1'b1; x_a = 32'd1000000; tag_a = 4'd7;
        tick();
        req_a = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_output("t5_valid", {31'd0, valid_a}, 0);
        check_output("t5_busy", {31'd0, busy_a}, 0);
        check_output("t5_root", {16'd0, root_a}, 0);
        check_output("t5_rem", {15'd0, rem_a}, 0);
        check_output("t5_tag", {28'd0, otag_a}, 0);
        #14;
        rst_n = 1'b1;
        vpulse = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (valid_a || busy_a) vpulse++;
        end
        check_output("t5_no_pulse", vpulse, 0);
        apply_stimulus(32'd99, 4'd2, lat);
        check_txn("t5_after", 9, 18, 2, lat);

        $display("[TB] 16-bit unit, two bits per cycle");
        sweep_one(0);
        sweep_one(1);
        sweep_one(2);
        sweep_one(3);
        sweep_one(4);
        sweep_one(65024);
        sweep_one(65025);
        sweep_one(65534);
        sweep_one(65535);
        for (int v = 5; v < 65536; v += 97) sweep_one(v);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
